// File: rtl/shuffle_select_if.sv
// Pick-request / pick-result bundle between the shuffle picker and its surroundings.
// The master side supplies LFSR words and requests; the slave side returns picks.
interface shuffle_select_if #(
    parameter int RAND_W = 14,
    parameter int IDX_W  = 6
);
    logic [RAND_W-1:0] rand_in;
    logic [IDX_W-1:0]  num_tracks;
    logic              req;
    logic              busy;
    logic [IDX_W-1:0]  idx;
    logic              idx_valid;
    logic              idx_ack;
    logic              err;

    modport master (
        output rand_in, num_tracks, req, idx_ack,
        input  busy, idx, idx_valid, err
    );

    modport slave (
        input  rand_in, num_tracks, req, idx_ack,
        output busy, idx, idx_valid, err
    );
endinterface

// File: rtl/shuffle_select.sv
// Shuffle track picker: mask-and-reject sampling of LFSR words into [0, num_tracks-1],
// optional no-immediate-repeat rule, bounded retries with a deterministic fallback.
module shuffle_select #(
    parameter int RAND_W    = 14,
    parameter int IDX_W     = 6,
    parameter int MAX_TRIES = 16,
    parameter int NO_REPEAT = 1
) (
    input logic              FPGA_CLK1_50,
    input logic              rst_n,
    shuffle_select_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_TRIES);
    localparam logic [CNT_W-1:0] LAST_TRY = CNT_W'(MAX_TRIES - 1);

    if (RAND_W < IDX_W || MAX_TRIES < 2) begin : g_bad_params
        $error("shuffle_select: RAND_W must be >= IDX_W and MAX_TRIES >= 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] n_lat;
    logic [IDX_W-1:0] mask;
    logic [CNT_W-1:0] try_cnt;
    logic [IDX_W-1:0] last;
    logic             has_last;
    logic [IDX_W-1:0] idx_q;
    logic             idx_valid_q;
    logic             busy_q;
    logic             err_q;

    logic [IDX_W-1:0] n_minus1;
    logic [IDX_W-1:0] mask_next;
    logic [IDX_W-1:0] cand;
    logic             cand_ok;
    logic [IDX_W:0]   last_inc;
    logic [IDX_W-1:0] fallback;
    logic [IDX_W-1:0] pick;

    // Smearing n-1 rightwards yields the smallest all-ones mask covering every legal index.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        n_minus1  = bus.num_tracks - IDX_W'(1);
        mask_next = n_minus1;
        for (int i = 1; i < IDX_W; i++) begin
            mask_next = mask_next | (n_minus1 >> i);
        end
    end

    always_comb begin
        cand     = bus.rand_in[IDX_W-1:0] & mask;
        cand_ok  = (cand < n_lat) &&
                   ((NO_REPEAT == 0) || (n_lat == IDX_W'(1)) || !has_last || (cand != last));
        // Widened increment so last+1 cannot wrap before the range test against n_lat.
        last_inc = has_last ? ({1'b0, last} + (IDX_W + 1)'(1)) : '0;
        fallback = (last_inc >= {1'b0, n_lat}) ? '0 : last_inc[IDX_W-1:0];
        pick     = cand_ok ? cand : fallback;
    end

    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge FPGA_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            n_lat       <= '0;
            mask        <= '0;
            try_cnt     <= '0;
            last        <= '0;
            has_last    <= 1'b0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        if (bus.num_tracks != '0) begin
                            n_lat   <= bus.num_tracks;
                            mask    <= mask_next;
                            try_cnt <= '0;
                            busy_q  <= 1'b1;
                            state   <= DRAW;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                DRAW: begin
                    // The last permitted reject takes the fallback instead of drawing again.
                    if (cand_ok || try_cnt == LAST_TRY) begin
                        idx_q       <= pick;
                        last        <= pick;
                        has_last    <= 1'b1;
                        idx_valid_q <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        try_cnt <= try_cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (bus.idx_ack) begin
                        idx_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.idx       = idx_q;
    assign bus.idx_valid = idx_valid_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_shuffle_select.sv
// Bench for shuffle_select: directed vector table, hand-written corner sequences,
// and randomized picks checked against a draw-by-draw reference model.
module tb_shuffle_select;
    localparam int RAND_W    = 14;
    localparam int IDX_W     = 6;
    localparam int MAX_TRIES = 16;

    typedef struct {
        int                n;
        logic [RAND_W-1:0] w [4];
        int                nw;
        int                exp_idx;
        int                exp_lat;
    } vec_t;

    logic FPGA_CLK1_50 = 1'b0;
    logic rst_n        = 1'b0;
    always #10 FPGA_CLK1_50 = ~FPGA_CLK1_50;

    shuffle_select_if #(.RAND_W(RAND_W), .IDX_W(IDX_W)) bus ();
    shuffle_select_if #(.RAND_W(RAND_W), .IDX_W(IDX_W)) bus2 ();
    assign bus2.rand_in    = bus.rand_in;
    assign bus2.num_tracks = bus.num_tracks;

    shuffle_select #(.RAND_W(RAND_W), .IDX_W(IDX_W), .MAX_TRIES(MAX_TRIES), .NO_REPEAT(1)) dut (
        .FPGA_CLK1_50 (FPGA_CLK1_50),
        .rst_n        (rst_n),
        .bus          (bus)
    );

    shuffle_select #(.RAND_W(RAND_W), .IDX_W(IDX_W), .MAX_TRIES(MAX_TRIES), .NO_REPEAT(0)) dut_rep (
        .FPGA_CLK1_50 (FPGA_CLK1_50),
        .rst_n        (rst_n),
        .bus          (bus2)
    );

    int                checks   = 0;
    int                failures = 0;
    logic [RAND_W-1:0] wq [$];
    vec_t              tbl [$];
    int                m_last = 0;
    bit                m_has  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input int n, input logic [RAND_W-1:0] w0, input logic [RAND_W-1:0] w1,
                           input logic [RAND_W-1:0] w2, input int nw, input int ei, input int el);
        vec_t v;
        v.n = n; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = '0;
        v.nw = nw; v.exp_idx = ei; v.exp_lat = el;
        tbl.push_back(v);
    endtask

    // Behavioural model: walk the draws in order, applying the acceptance rules directly.
    function automatic void model_pick(input int n, input logic [RAND_W-1:0] w [$],
                                       output int idx, output int lat);
        int m = 0;
        int fb;
        while (m < n - 1) m = m * 2 + 1;
        for (int k = 0; k < MAX_TRIES; k++) begin
            int c = int'(w[k < w.size() ? k : w.size() - 1]) & m;
            if (c < n && (n == 1 || !m_has || c != m_last)) begin
                idx = c; lat = k + 1; m_last = c; m_has = 1'b1;
                return;
            end
        end
        fb = m_has ? m_last + 1 : 0;
        if (fb >= n) fb = 0;
        idx = fb; lat = MAX_TRIES; m_last = fb; m_has = 1'b1;
    endfunction

    task automatic start_req(input int n);
        @(negedge FPGA_CLK1_50);
        bus.req        = 1'b1;
        bus.num_tracks = IDX_W'(n);
        @(negedge FPGA_CLK1_50);
        bus.req = 1'b0;
        check("busy_after_req", int'(bus.busy), 1);
    endtask

    task automatic run_draw(input string name, input int exp_idx, input int exp_lat);
        int lat = 0;
        bit got = 1'b0;
        for (int k = 0; k < MAX_TRIES + 2 && !got; k++) begin
            bus.rand_in = (k < wq.size()) ? wq[k] : wq[wq.size() - 1];
            @(negedge FPGA_CLK1_50);
            lat++;
            if (bus.idx_valid) got = 1'b1;
        end
        check({name, "_valid"}, int'(got), 1);
        check({name, "_idx"}, int'(bus.idx), exp_idx);
        check({name, "_lat"}, lat, exp_lat);
    endtask

    task automatic ack_pick();
        bus.idx_ack = 1'b1;
        @(negedge FPGA_CLK1_50);
        bus.idx_ack = 1'b0;
        check("valid_after_ack", int'(bus.idx_valid), 0);
        check("busy_after_ack", int'(bus.busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rand_in = '0; bus.num_tracks = '0; bus.req = 1'b0; bus.idx_ack = 1'b0;
        bus2.req = 1'b0; bus2.idx_ack = 1'b0;

        // Reset state
        repeat (2) @(negedge FPGA_CLK1_50);
        check("rst_idx", int'(bus.idx), 0);
        check("rst_valid", int'(bus.idx_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_err", int'(bus.err), 0);
        rst_n = 1'b1;

        // Zero-track request: one-cycle err pulse, never busy
        @(negedge FPGA_CLK1_50);
        bus.req = 1'b1; bus.num_tracks = '0;
        @(negedge FPGA_CLK1_50);
        bus.req = 1'b0;
        check("err_pulse", int'(bus.err), 1);
        check("err_busy", int'(bus.busy), 0);
        @(negedge FPGA_CLK1_50);
        check("err_cleared", int'(bus.err), 0);
        check("err_busy_after", int'(bus.busy), 0);

        // Directed vectors; each row depends on the last pick left by the row before
        add_vec(5,  14'h3FFF, 14'h0006, 14'h0003, 3, 3, 3);
        add_vec(5,  14'h0003, 14'h0001, 14'h0000, 2, 1, 2);
        add_vec(1,  14'h02A5, 14'h0000, 14'h0000, 1, 0, 1);
        add_vec(1,  14'h3FFF, 14'h0000, 14'h0000, 1, 0, 1);
        add_vec(1,  14'h1234, 14'h0000, 14'h0000, 1, 0, 1);
        add_vec(63, 14'h3FFF, 14'h00C5, 14'h0000, 2, 5, 2);
        add_vec(9,  14'h000F, 14'h0009, 14'h0008, 3, 8, 3);
        add_vec(3,  14'h0003, 14'h0000, 14'h0000, 1, 0, MAX_TRIES);
        add_vec(5,  14'h0004, 14'h0000, 14'h0000, 1, 4, 1);
        add_vec(5,  14'h0007, 14'h0000, 14'h0000, 1, 0, MAX_TRIES);
        add_vec(5,  14'h0002, 14'h0000, 14'h0000, 1, 2, 1);
        add_vec(5,  14'h0007, 14'h0000, 14'h0000, 1, 3, MAX_TRIES);
        add_vec(8,  14'h0008, 14'h0000, 14'h0000, 1, 0, 1);
        add_vec(5,  14'h0003, 14'h0000, 14'h0000, 1, 3, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            wq = {};
            for (int j = 0; j < tbl[i].nw; j++) wq.push_back(tbl[i].w[j]);
            start_req(tbl[i].n);
            run_draw($sformatf("vec%0d", i), tbl[i].exp_idx, tbl[i].exp_lat);
            ack_pick();
        end

        // Handshake: long hold with req/num_tracks noise, then ack and immediate re-request
        start_req(5);
        wq = {14'h0001};
        run_draw("hold", 1, 1);
        for (int c = 0; c < 10; c++) begin
            bus.req        = ~bus.req;
            bus.num_tracks = IDX_W'($urandom_range(0, 63));
            bus.rand_in    = RAND_W'($urandom);
            @(negedge FPGA_CLK1_50);
            check("hold_idx", int'(bus.idx), 1);
            check("hold_valid", int'(bus.idx_valid), 1);
        end
        bus.num_tracks = IDX_W'(5);
        bus.idx_ack    = 1'b1;
        bus.req        = 1'b1;
        @(negedge FPGA_CLK1_50);
        bus.idx_ack = 1'b0;
        check("ack_edge_valid", int'(bus.idx_valid), 0);
        check("ack_edge_busy", int'(bus.busy), 0);
        @(negedge FPGA_CLK1_50);
        bus.req = 1'b0;
        check("rereq_busy", int'(bus.busy), 1);
        wq = {14'h0002};
        run_draw("rereq", 2, 1);
        ack_pick();

        // Reset mid-DRAW, then the old last pick must be accepted again
        start_req(5);
        bus.rand_in = 14'h0007;
        repeat (4) @(negedge FPGA_CLK1_50);
        rst_n = 1'b0;
        #2;
        check("abort_idx", int'(bus.idx), 0);
        check("abort_valid", int'(bus.idx_valid), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_err", int'(bus.err), 0);
        @(negedge FPGA_CLK1_50);
        rst_n = 1'b1;
        start_req(5);
        wq = {14'h0002};
        run_draw("post_reset", 2, 1);
        ack_pick();

        // Repeat allowed when the no-repeat rule is disabled
        for (int p = 0; p < 2; p++) begin
            @(negedge FPGA_CLK1_50);
            bus2.req = 1'b1; bus.num_tracks = IDX_W'(5);
            @(negedge FPGA_CLK1_50);
            bus2.req = 1'b0; bus.rand_in = 14'h0003;
            @(negedge FPGA_CLK1_50);
            check("rep_valid", int'(bus2.idx_valid), 1);
            check("rep_idx", int'(bus2.idx), 3);
            bus2.idx_ack = 1'b1;
            @(negedge FPGA_CLK1_50);
            bus2.idx_ack = 1'b0;
        end

        // Randomized picks against the reference model, starting from a clean reset
        @(negedge FPGA_CLK1_50);
        rst_n = 1'b0;
        @(negedge FPGA_CLK1_50);
        rst_n = 1'b1;
        m_has = 1'b0; m_last = 0;
        for (int r = 0; r < 40; r++) begin
            int n, ei, el, dly;
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 63);
            wq = {};
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < MAX_TRIES + 2; k++) wq.push_back(14'h3FFF);
            end else begin
                for (int k = 0; k < MAX_TRIES + 2; k++) wq.push_back(RAND_W'($urandom));
            end
            model_pick(n, wq, ei, el);
            start_req(n);
            run_draw("rnd", ei, el);
            dly = $urandom_range(0, 2);
            for (int d = 0; d < dly; d++) begin
                @(negedge FPGA_CLK1_50);
                check("rnd_hold_idx", int'(bus.idx), ei);
            end
            ack_pick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
